// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered decode stage with register file, load-use stall
// and ID-resolved BEQ/BNE/J. Optional macro: ID_BRANCH_FWD_EN.
module id_stage_pipe #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc4,
   input  logic [31:0]     in_inst,
   input  logic            we,
   input  logic [4:0]      wdest,
   input  logic [XLEN-1:0] wdi,
   input  logic [4:0]      ex_rd,
   input  logic            ex_wreg,
   input  logic            ex_m2reg,
   input  logic [4:0]      mem_rd,
   input  logic            mem_wreg,
   input  logic [XLEN-1:0] ex_fwd,
   input  logic [XLEN-1:0] mem_fwd,
   output logic            redirect,
   output logic [XLEN-1:0] target,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_dest,
   output logic [2:0]      out_aluc,
   output logic            out_wreg,
   output logic            out_m2reg,
   output logic            out_wmem,
   output logic            out_alusrc_b
);

   logic [5:0]  op;
   logic [4:0]  rd, rs, rt;
   logic [15:0] imm16;

   assign op    = in_inst[31:26];
   assign imm16 = in_inst[25:10];
   assign rd    = in_inst[14:10];
   assign rs    = in_inst[9:5];
   assign rt    = in_inst[4:0];

   logic is_r, is_addi, is_lw, is_sw;
   logic is_beq, is_bne, is_j, is_br;

   assign is_r    = (op == 6'd0);
   assign is_addi = (op == 6'd1);
   assign is_lw   = (op == 6'd2);
   assign is_sw   = (op == 6'd3);
   assign is_beq  = (op == 6'd4);
   assign is_bne  = (op == 6'd5);
   assign is_j    = (op == 6'd6);
   assign is_br   = is_beq | is_bne;

   logic       d_emit, d_wreg, d_m2reg;
   logic       d_wmem, d_alusrc_b, d_sext;
   logic [2:0] d_aluc;
   logic [4:0] d_dest;
   logic       use_rs, use_rt;

   always_comb begin
      d_emit     = 1'b0;
      d_wreg     = 1'b0;
      d_m2reg    = 1'b0;
      d_wmem     = 1'b0;
      d_alusrc_b = 1'b0;
      d_sext     = 1'b0;
      d_aluc     = 3'd0;
      d_dest     = 5'd0;
      use_rs     = 1'b0;
      use_rt     = 1'b0;
      unique case (1'b1)
         is_r: begin
            d_emit = 1'b1;
            d_wreg = 1'b1;
            d_aluc = in_inst[22:20];
            d_dest = rd;
            use_rs = 1'b1;
            use_rt = 1'b1;
         end
         is_addi: begin
            d_emit     = 1'b1;
            d_wreg     = 1'b1;
            d_alusrc_b = 1'b1;
            d_sext     = 1'b1;
            d_dest     = rt;
            use_rs     = 1'b1;
         end
         is_lw: begin
            d_emit     = 1'b1;
            d_wreg     = 1'b1;
            d_m2reg    = 1'b1;
            d_alusrc_b = 1'b1;
            d_sext     = 1'b1;
            d_dest     = rt;
            use_rs     = 1'b1;
         end
         is_sw: begin
            d_emit     = 1'b1;
            d_wmem     = 1'b1;
            d_alusrc_b = 1'b1;
            d_sext     = 1'b1;
            use_rs     = 1'b1;
            use_rt     = 1'b1;
         end
         is_beq, is_bne: begin
            d_sext = 1'b1;
            use_rs = 1'b1;
            use_rt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // r0 and indices >= NREG are not stored at all
   logic [XLEN-1:0] rf [1:NREG-1];

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 1; i < NREG; i++) rf[i] <= '0;
      end else if (we && wdest != 5'd0 && int'(wdest) < NREG) begin
         rf[wdest] <= wdi;
      end
   end

   logic [XLEN-1:0] rs_val, rt_val;

   always_comb begin
      rs_val = '0;
      rt_val = '0;
      if (rs != 5'd0 && int'(rs) < NREG)
         rs_val = (we && wdest == rs) ? wdi : rf[rs];
      if (rt != 5'd0 && int'(rt) < NREG)
         rt_val = (we && wdest == rt) ? wdi : rf[rt];
   end

   logic ex_rs, ex_rt, mem_rs, mem_rt;

   assign ex_rs  = ex_wreg & (ex_rd == rs) & (rs != 5'd0);
   assign ex_rt  = ex_wreg & (ex_rd == rt) & (rt != 5'd0);
   assign mem_rs = mem_wreg & (mem_rd == rs) & (rs != 5'd0);
   assign mem_rt = mem_wreg & (mem_rd == rt) & (rt != 5'd0);

   logic [XLEN-1:0] ba, bb;
   logic            br_haz;

`ifdef ID_BRANCH_FWD_EN
   assign ba     = ex_rs ? ex_fwd : (mem_rs ? mem_fwd : rs_val);
   assign bb     = ex_rt ? ex_fwd : (mem_rt ? mem_fwd : rt_val);
   assign br_haz = 1'b0;
`else
   logic unused_fwd;
   assign unused_fwd = ^{ex_fwd, mem_fwd};
   assign ba     = rs_val;
   assign bb     = rt_val;
   assign br_haz = is_br & (ex_rs | ex_rt | mem_rs | mem_rt);
`endif

   logic lu, stall, hold, accept, issue, taken;

   assign lu = ex_m2reg & ((use_rs & ex_rs) | (use_rt & ex_rt));
   assign stall    = in_valid & (lu | br_haz);
   assign hold     = out_valid & ~out_ready;
   assign in_ready = ~hold & ~stall;
   assign accept   = in_valid & in_ready & ~clr;
   assign issue    = accept & d_emit;

   assign taken = is_j
                | (is_beq & (ba == bb))
                | (is_bne & (ba != bb));

   logic [XLEN-1:0] imm_ext, br_tgt, j_tgt;

   assign imm_ext = d_sext ? {{(XLEN-16){imm16[15]}}, imm16}
                           : {{(XLEN-16){1'b0}}, imm16};
   assign br_tgt  = in_pc4 + (imm_ext << 2);
   assign j_tgt   = {in_pc4[XLEN-1:28], in_inst[25:0], 2'b00};

   assign redirect = accept & taken;
   assign target   = redirect ? (is_j ? j_tgt : br_tgt) : '0;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         out_valid    <= 1'b0;
         out_a        <= '0;
         out_b        <= '0;
         out_imm      <= '0;
         out_dest     <= 5'd0;
         out_aluc     <= 3'd0;
         out_wreg     <= 1'b0;
         out_m2reg    <= 1'b0;
         out_wmem     <= 1'b0;
         out_alusrc_b <= 1'b0;
      end else if (!hold) begin
         out_valid    <= issue;
         out_a        <= issue ? rs_val : '0;
         out_b        <= issue ? rt_val : '0;
         out_imm      <= issue ? imm_ext : '0;
         out_dest     <= issue ? d_dest : 5'd0;
         out_aluc     <= issue ? d_aluc : 3'd0;
         out_wreg     <= issue & d_wreg;
         out_m2reg    <= issue & d_m2reg;
         out_wmem     <= issue & d_wmem;
         out_alusrc_b <= issue & d_alusrc_b;
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vector table plus hand-written stall,
// branch, backpressure and reset sequences for id_stage_pipe.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        clr;
   logic        in_valid, in_ready;
   logic [31:0] in_pc4, in_inst;
   logic        we;
   logic [4:0]  wdest;
   logic [31:0] wdi;
   logic [4:0]  ex_rd, mem_rd;
   logic        ex_wreg, ex_m2reg, mem_wreg;
   logic [31:0] ex_fwd, mem_fwd;
   logic        redirect;
   logic [31:0] target;
   logic        out_valid, out_ready;
   logic [31:0] out_a, out_b, out_imm;
   logic [4:0]  out_dest;
   logic [2:0]  out_aluc;
   logic        out_wreg, out_m2reg, out_wmem, out_alusrc_b;

   always #5 clk = ~clk;

   id_stage_pipe dut (
      .clk(clk), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc4(in_pc4), .in_inst(in_inst),
      .we(we), .wdest(wdest), .wdi(wdi),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg),
      .ex_fwd(ex_fwd), .mem_fwd(mem_fwd),
      .redirect(redirect), .target(target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
      .out_dest(out_dest), .out_aluc(out_aluc),
      .out_wreg(out_wreg), .out_m2reg(out_m2reg),
      .out_wmem(out_wmem), .out_alusrc_b(out_alusrc_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [2:0] f,
      input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
      return {6'd0, 3'd0, f, 5'd0, d, s, t};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
      return {op, im, s, t};
   endfunction

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc4;
      logic [37:0] wbk;
      logic [6:0]  ex;
      logic        ir;
      logic        rdr;
      logic [31:0] tgt;
      logic        ov;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic [2:0]  aluc;
      logic [3:0]  fl;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic [31:0] inst, input logic [31:0] pc4,
      input logic [37:0] wbk, input logic [6:0] ex,
      input logic ir, input logic rdr, input logic [31:0] tgt,
      input logic ov, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] imm, input logic [4:0] dest,
      input logic [2:0] aluc, input logic [3:0] fl);
      vec_t v;
      v.inst = inst; v.pc4 = pc4; v.wbk = wbk; v.ex = ex;
      v.ir = ir; v.rdr = rdr; v.tgt = tgt; v.ov = ov;
      v.a = a; v.b = b; v.imm = imm; v.dest = dest;
      v.aluc = aluc; v.fl = fl;
      vt.push_back(v);
   endtask

   task automatic idle();
      in_valid = 1'b0; in_inst = 32'd0; in_pc4 = 32'd0;
      we = 1'b0; wdest = 5'd0; wdi = 32'd0;
      ex_rd = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
      mem_rd = 5'd0; mem_wreg = 1'b0;
      ex_fwd = 32'd0; mem_fwd = 32'd0;
      out_ready = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      idle();
      we = 1'b1; wdest = a; wdi = d;
      step();
      we = 1'b0;
   endtask

   function automatic logic [3:0] flags();
      return {out_wreg, out_m2reg, out_wmem, out_alusrc_b};
   endfunction

   localparam logic [31:0] Z = 32'd0;
   localparam logic [37:0] NW = 38'd0;
   localparam logic [6:0]  NX = 7'd0;
   localparam logic [6:0]  LD2 = {5'd2, 2'b11};

   initial begin
      // op field values: 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 7 unused
      add(enc_r(3'd2, 5'd8, 5'd1, 5'd2), Z, NW, NX,
          1'b1, 1'b0, Z, 1'b1, 32'h5, 32'h20, 32'h808, 5'd8, 3'd2, 4'b1000);
      add(enc_i(6'd1, 5'd3, 5'd4, 16'h1), Z, {1'b1, 5'd3, 32'h1234}, NX,
          1'b1, 1'b0, Z, 1'b1, 32'h1234, Z, 32'h1, 5'd4, 3'd0, 4'b1001);
      add(enc_r(3'd0, 5'd9, 5'd3, 5'd5), Z, NW, NX,
          1'b1, 1'b0, Z, 1'b1, 32'h1234, 32'h7, 32'h9, 5'd9, 3'd0, 4'b1000);
      add(enc_i(6'd1, 5'd1, 5'd10, 16'h8000), Z, NW, NX,
          1'b1, 1'b0, Z, 1'b1, 32'h5, Z, 32'hFFFF8000, 5'd10, 3'd0, 4'b1001);
      add(enc_i(6'd2, 5'd2, 5'd11, 16'hFFFC), Z, NW, NX,
          1'b1, 1'b0, Z, 1'b1, 32'h20, Z, 32'hFFFFFFFC, 5'd11, 3'd0, 4'b1101);
      add(enc_i(6'd3, 5'd2, 5'd5, 16'h4), Z, NW, NX,
          1'b1, 1'b0, Z, 1'b1, 32'h20, 32'h7, 32'h4, 5'd0, 3'd0, 4'b0011);
      add(enc_i(6'd7, 5'd1, 5'd2, 16'h5), Z, NW, NX,
          1'b1, 1'b0, Z, 1'b0, Z, Z, Z, 5'd0, 3'd0, 4'b0000);
      add(enc_i(6'd4, 5'd1, 5'd1, 16'hFFFF), 32'h100, NW, NX,
          1'b1, 1'b1, 32'hFC, 1'b0, Z, Z, Z, 5'd0, 3'd0, 4'b0000);
      add(enc_i(6'd5, 5'd1, 5'd1, 16'hFFFF), 32'h100, NW, NX,
          1'b1, 1'b0, Z, 1'b0, Z, Z, Z, 5'd0, 3'd0, 4'b0000);
      add(enc_i(6'd5, 5'd1, 5'd2, 16'h3), 32'h200, NW, NX,
          1'b1, 1'b1, 32'h20C, 1'b0, Z, Z, Z, 5'd0, 3'd0, 4'b0000);
      add(enc_i(6'd4, 5'd1, 5'd2, 16'h3), 32'h200, NW, NX,
          1'b1, 1'b0, Z, 1'b0, Z, Z, Z, 5'd0, 3'd0, 4'b0000);
      add({6'd6, 26'h40}, 32'hF0000010, NW, NX,
          1'b1, 1'b1, 32'hF0000100, 1'b0, Z, Z, Z, 5'd0, 3'd0, 4'b0000);
      add(enc_r(3'd0, 5'd8, 5'd1, 5'd2), Z, NW, LD2,
          1'b0, 1'b0, Z, 1'b0, Z, Z, Z, 5'd0, 3'd0, 4'b0000);
      add(enc_i(6'd1, 5'd1, 5'd2, 16'h7), Z, NW, LD2,
          1'b1, 1'b0, Z, 1'b1, 32'h5, 32'h20, 32'h7, 5'd2, 3'd0, 4'b1001);
      add(enc_r(3'd1, 5'd12, 5'd2, 5'd1), Z, NW, {5'd2, 2'b10},
          1'b1, 1'b0, Z, 1'b1, 32'h20, 32'h5, 32'h40C, 5'd12, 3'd1, 4'b1000);
      add(enc_r(3'd3, 5'd13, 5'd0, 5'd0), Z, NW, {5'd0, 2'b11},
          1'b1, 1'b0, Z, 1'b1, Z, Z, 32'hC0D, 5'd13, 3'd3, 4'b1000);
      add(enc_i(6'd5, 5'd2, 5'd1, 16'h3), 32'h200, NW, LD2,
          1'b0, 1'b0, Z, 1'b0, Z, Z, Z, 5'd0, 3'd0, 4'b0000);
      add(enc_i(6'd3, 5'd1, 5'd2, 16'h0), Z, NW, LD2,
          1'b0, 1'b0, Z, 1'b0, Z, Z, Z, 5'd0, 3'd0, 4'b0000);
      add(enc_i(6'd2, 5'd1, 5'd2, 16'h0), Z, NW, LD2,
          1'b1, 1'b0, Z, 1'b1, 32'h5, 32'h20, Z, 5'd2, 3'd0, 4'b1101);

      // reset with a taken-looking branch on the input
      clr = 1'b1;
      idle();
      in_valid = 1'b1;
      in_inst = enc_i(6'd4, 5'd0, 5'd0, 16'h1);
      in_pc4 = 32'h10;
      #12;
      chk1("rst out_valid", out_valid, 1'b0);
      chk("rst out_a", out_a, Z);
      chk("rst out_imm", out_imm, Z);
      chk("rst out_dest", {27'd0, out_dest}, Z);
      chk("rst flags", {28'd0, flags()}, Z);
      chk1("rst redirect", redirect, 1'b0);
      chk("rst target", target, Z);
      clr = 1'b0;
      idle();
      #1;
      chk1("rst in_ready", in_ready, 1'b1);
      step();

      wb(5'd1, 32'h5);
      wb(5'd2, 32'h20);
      wb(5'd5, 32'h7);
      wb(5'd6, 32'h9);
      wb(5'd31, 32'hDEAD);

      foreach (vt[i]) begin
         idle();
         in_valid = 1'b1;
         in_inst = vt[i].inst;
         in_pc4 = vt[i].pc4;
         {we, wdest, wdi} = vt[i].wbk;
         {ex_rd, ex_wreg, ex_m2reg} = vt[i].ex;
         #1;
         chk1($sformatf("v%0d in_ready", i), in_ready, vt[i].ir);
         chk1($sformatf("v%0d redirect", i), redirect, vt[i].rdr);
         chk($sformatf("v%0d target", i), target, vt[i].tgt);
         step();
         chk1($sformatf("v%0d out_valid", i), out_valid, vt[i].ov);
         chk($sformatf("v%0d out_a", i), out_a, vt[i].a);
         chk($sformatf("v%0d out_b", i), out_b, vt[i].b);
         chk($sformatf("v%0d out_imm", i), out_imm, vt[i].imm);
         chk($sformatf("v%0d out_dest", i), {27'd0, out_dest},
             {27'd0, vt[i].dest});
         chk($sformatf("v%0d out_aluc", i), {29'd0, out_aluc},
             {29'd0, vt[i].aluc});
         chk($sformatf("v%0d flags", i), {28'd0, flags()},
             {28'd0, vt[i].fl});
      end

      // BEQ r5,r6 while EX writes r5 with 9 (r6 holds 9)
      idle();
      in_valid = 1'b1;
      in_inst = enc_i(6'd4, 5'd5, 5'd6, 16'h2);
      in_pc4 = 32'h300;
      ex_rd = 5'd5; ex_wreg = 1'b1; ex_fwd = 32'h9;
`ifdef ID_BRANCH_FWD_EN
      #1;
      chk1("fwd in_ready", in_ready, 1'b1);
      chk1("fwd redirect", redirect, 1'b1);
      chk("fwd target", target, 32'h308);
      step();
      in_inst = enc_r(3'd0, 5'd20, 5'd1, 5'd1);
      ex_wreg = 1'b0;
      #1;
      chk1("fwd redirect once", redirect, 1'b0);
      in_inst = enc_i(6'd4, 5'd5, 5'd6, 16'h2);
      ex_wreg = 1'b1; ex_fwd = 32'h1;
      mem_rd = 5'd5; mem_wreg = 1'b1; mem_fwd = 32'h9;
      #1;
      chk1("fwd ex priority", redirect, 1'b0);
      ex_wreg = 1'b0;
      #1;
      chk1("fwd mem", redirect, 1'b1);
      step();
`else
      #1;
      chk1("nofwd ex in_ready", in_ready, 1'b0);
      chk1("nofwd ex redirect", redirect, 1'b0);
      step();
      chk1("nofwd bubble", out_valid, 1'b0);
      ex_wreg = 1'b0;
      mem_rd = 5'd5; mem_wreg = 1'b1;
      #1;
      chk1("nofwd mem in_ready", in_ready, 1'b0);
      step();
      mem_wreg = 1'b0;
      we = 1'b1; wdest = 5'd5; wdi = 32'h9;
      #1;
      chk1("nofwd wb in_ready", in_ready, 1'b1);
      chk1("nofwd wb redirect", redirect, 1'b1);
      chk("nofwd wb target", target, 32'h308);
      step();
      idle();
      #1;
      chk1("nofwd redirect once", redirect, 1'b0);
`endif

      // load-use: one bubble, then issue once EX advances
      idle();
      in_valid = 1'b1;
      in_inst = enc_r(3'd0, 5'd16, 5'd2, 5'd1);
      ex_rd = 5'd2; ex_wreg = 1'b1; ex_m2reg = 1'b1;
      #1;
      chk1("lu in_ready", in_ready, 1'b0);
      step();
      chk1("lu bubble", out_valid, 1'b0);
      ex_wreg = 1'b0; ex_m2reg = 1'b0;
      mem_rd = 5'd2; mem_wreg = 1'b1;
      #1;
      chk1("lu retry in_ready", in_ready, 1'b1);
      step();
      chk1("lu issue valid", out_valid, 1'b1);
      chk("lu issue dest", {27'd0, out_dest}, 32'd16);

      // backpressure for 3 cycles with a taken branch waiting
      idle();
      in_valid = 1'b1;
      in_inst = enc_r(3'd0, 5'd14, 5'd1, 5'd2);
      step();
      chk1("bp first valid", out_valid, 1'b1);
      out_ready = 1'b0;
      in_inst = enc_i(6'd4, 5'd1, 5'd1, 16'h1);
      in_pc4 = 32'h40;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk1($sformatf("bp%0d in_ready", k), in_ready, 1'b0);
         chk1($sformatf("bp%0d redirect", k), redirect, 1'b0);
         chk1($sformatf("bp%0d out_valid", k), out_valid, 1'b1);
         chk($sformatf("bp%0d out_dest", k), {27'd0, out_dest}, 32'd14);
         chk($sformatf("bp%0d out_a", k), out_a, 32'h5);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk1("bp release in_ready", in_ready, 1'b1);
      chk1("bp release redirect", redirect, 1'b1);
      chk("bp release target", target, 32'h44);
      step();
      chk1("bp branch bubble", out_valid, 1'b0);
      in_inst = enc_r(3'd0, 5'd15, 5'd1, 5'd2);
      in_pc4 = 32'd0;
      step();
      chk1("bp next valid", out_valid, 1'b1);
      chk("bp next dest", {27'd0, out_dest}, 32'd15);

      // reset asserted mid-stall
      idle();
      in_valid = 1'b1;
      in_inst = enc_r(3'd0, 5'd17, 5'd1, 5'd2);
      step();
      chk1("mr pre valid", out_valid, 1'b1);
      in_inst = enc_r(3'd0, 5'd18, 5'd1, 5'd2);
      ex_rd = 5'd1; ex_wreg = 1'b1; ex_m2reg = 1'b1;
      #1;
      chk1("mr stall", in_ready, 1'b0);
      #2;
      clr = 1'b1;
      #1;
      chk1("mr out_valid", out_valid, 1'b0);
      chk("mr out_a", out_a, Z);
      chk("mr out_dest", {27'd0, out_dest}, Z);
      chk("mr flags", {28'd0, flags()}, Z);
      step();
      clr = 1'b0;
      idle();
      step();
      chk1("mr dropped", out_valid, 1'b0);
      for (int r = 1; r < 32; r++) begin
         idle();
         in_valid = 1'b1;
         in_inst = enc_r(3'd0, 5'd1, 5'(r), 5'(r));
         step();
         chk($sformatf("mr r%0d a", r), out_a, Z);
         chk($sformatf("mr r%0d b", r), out_b, Z);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
